ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  PS/2 keyboard front end feeding vga_controller movement inputs (kup/kdown/kleft/kright).
//  - Samples raw keyclk/keyinput, deframes 11-bit PS/2 frames and tracks E0/F0 prefixes.
//  - Outputs each completed scan code plus level-held flags for the four arrow keys.
//  - Replaces the "last byte equals 8'h6b" compare with true make/break tracking.
// PARAMETERS
//  SYNC_STAGES  2      flops per synchroniser chain on keyclk/keyinput (min 2)
//  TIMEOUT_CYC  50000  clk cycles with no keyclk falling edge before a partial frame aborts
//  TO_W         16     timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYC
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-low reset
//  keyclk      in   1  raw PS/2 clock (asynchronous)
//  keyinput    in   1  raw PS/2 data (asynchronous)
//  scan_code   out  8  last accepted code byte, prefixes excluded
//  code_valid  out  1  1-cycle pulse when scan_code updates
//  is_ext      out  1  qualifies code_valid: code was preceded by E0
//  is_break    out  1  qualifies code_valid: code was preceded by F0 (key release)
//  kup         out  1  level: E0 75 held
//  kdown       out  1  level: E0 72 held
//  kleft       out  1  level: E0 6B held
//  kright      out  1  level: E0 74 held
//  frame_err   out  1  1-cycle pulse on framing, parity or timeout error
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM IDLE, prefix flags clear, counters 0.
//  Sync: keyclk/keyinput pass through SYNC_STAGES flops.
//   fall = synced keyclk 1->0; data is sampled only on fall.
//  Frame FSM, advancing only on fall:
//   IDLE:   bit=0 -> DATA (cnt=0); bit=1 -> stay in IDLE (spurious edge, no error).
//   DATA:   shift right (LSB first), cnt++; after 8th bit -> PARITY.
//   PARITY: capture bit -> STOP.
//   STOP:   bit=1 and parity OK -> accept byte; otherwise frame_err pulse.
//           Either way -> IDLE.
//  Parity is odd: XOR of 8 data bits and parity bit must equal 1.
//  Timeout: counter clears on every fall and counts while FSM != IDLE.
//   Reaching TIMEOUT_CYC -> frame_err pulse, FSM IDLE, prefix flags cleared.
//  Byte accept, evaluated in the cycle after the STOP sample:
//   E0 -> set ext_pf; no code_valid.
//   F0 -> set brk_pf; no code_valid.
//   Any other byte -> scan_code=byte, is_ext=ext_pf, is_break=brk_pf, code_valid=1;
//    then clear both prefix flags.
//  Accept latency: code_valid asserts 2 clk after the fall that samples the stop bit.
//   scan_code/is_ext/is_break hold until the next code_valid.
//  Arrow flags update in the same cycle as code_valid:
//   only when is_ext=1 and byte is in {75,72,6B,74};
//   set on make, clear on break; repeated makes (typematic) leave the flag at 1.
//   Non-ext 75/72/6B/74 (keypad) do not affect the flags.
//  Multiple arrows may be held at once; this block does not arbitrate.
//  E0 F0 and F0 E0 orderings both yield is_ext=is_break=1.
//  A frame error does not clear prefix flags; only a timeout or reset does.
//  rst mid-frame: partial frame discarded, no code_valid/frame_err, all flags 0.
// CONFIGURATION
//  PS2_PARITY_CHK_EN
//   defined:   parity is checked as above; a bad parity drops the byte and pulses frame_err.
//   undefined: parity bit is sampled and ignored; only start/stop/timeout raise frame_err.
// TESTING
//  1 Frame 0x1C (start0, data LSB-first, parity0, stop1), fall spacing 2000 clk
//    -> code_valid x1, scan_code=1C, is_ext=0, is_break=0.
//  2 Bytes E0,6B -> kleft=1, code_valid with is_ext=1.
//    Then E0,F0,6B -> kleft=0, is_break=1.
//  3 Typematic E0,75 x3 -> kup stays 1, three code_valid pulses.
//    Then E0,F0,75 -> kup=0.
//  4 Frame 0x1C with parity=1 -> frame_err pulse, no code_valid.
//    With PS2_PARITY_CHK_EN undefined -> code_valid, scan_code=1C.
//  5 Abort after 4 data bits, idle 50000 clk -> frame_err pulse, FSM IDLE.
//    Next full frame 0x29 -> scan_code=29.
//  6 E0 then stop-bit=0 on 0x74 (framing error), then full 0x74
//    -> frame_err, then code_valid with is_ext=1, kright=1.
//    rst low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard front end.
//   Synchronises raw keyclk/keyinput, deframes 11-bit PS/2 frames,
//   tracks E0 (extended) / F0 (break) prefixes, reports each scan code
//   and holds make/break level flags for the four extended arrow keys.
// Optional feature macro: PS2_PARITY_CHK_EN
//   defined   -> odd parity is checked; a bad parity drops the byte and pulses frame_err
//   undefined -> the parity bit is clocked past and ignored
module ps2_key_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keyclk,
  input  logic       keyinput,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       is_ext,
  output logic       is_break,
  output logic       kup,
  output logic       kdown,
  output logic       kleft,
  output logic       kright,
  output logic       frame_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_kclk_sync;
  logic [SYNC_STAGES-1:0] r_kdat_sync;
  logic                   r_kclk_prev;
  logic [1:0]             r_state;
  logic [2:0]             r_cnt;
  logic [7:0]             r_shift;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_acc_vld;
  logic [7:0]             r_acc_byte;
  logic                   r_ext_pf;
  logic                   r_brk_pf;

  logic w_fall;
  logic w_bit;
  logic w_timeout;
  logic w_par_ok;

  assign w_fall    = r_kclk_prev & ~r_kclk_sync[SYNC_STAGES-1];
  assign w_bit     = r_kdat_sync[SYNC_STAGES-1];
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST);

`ifdef PS2_PARITY_CHK_EN
  logic r_par;
  // Odd parity: data bits XOR parity bit must be 1.
  assign w_par_ok = ^{r_shift, r_par};

  // Capture the parity bit when its falling edge arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_par <= 1'b0;
    else if (w_fall && r_state == S_PARITY)  r_par <= w_bit;
  end
`else
  assign w_par_ok = 1'b1;
`endif

  // Synchronisers; idle PS/2 lines are high, so reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kclk_sync <= '1;
      r_kdat_sync <= '1;
      r_kclk_prev <= 1'b1;
    end else begin
      r_kclk_sync <= {r_kclk_sync[SYNC_STAGES-2:0], keyclk};
      r_kdat_sync <= {r_kdat_sync[SYNC_STAGES-2:0], keyinput};
      r_kclk_prev <= r_kclk_sync[SYNC_STAGES-1];
    end
  end

  // Frame FSM: advances on keyclk falls, aborts a stalled frame on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_to_cnt   <= '0;
      r_acc_vld  <= 1'b0;
      r_acc_byte <= '0;
      frame_err  <= 1'b0;
    end else begin
      r_acc_vld <= 1'b0;
      frame_err <= 1'b0;
      if (w_timeout) begin
        r_state   <= S_IDLE;
        r_to_cnt  <= '0;
        frame_err <= 1'b1;
      end else if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            // A high bit here is a spurious edge, not a start bit.
            if (!w_bit) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {w_bit, r_shift[7:1]};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: r_state <= S_STOP;
          default: begin
            if (w_bit && w_par_ok) begin
              r_acc_vld  <= 1'b1;
              r_acc_byte <= r_shift;
            end else begin
              frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        endcase
      end else if (r_state != S_IDLE) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Byte decode: prefixes latch, other bytes publish a code and update arrow levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext_pf   <= 1'b0;
      r_brk_pf   <= 1'b0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      is_ext     <= 1'b0;
      is_break   <= 1'b0;
      kup        <= 1'b0;
      kdown      <= 1'b0;
      kleft      <= 1'b0;
      kright     <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (w_timeout) begin
        r_ext_pf <= 1'b0;
        r_brk_pf <= 1'b0;
      end else if (r_acc_vld) begin
        if (r_acc_byte == 8'hE0) begin
          r_ext_pf <= 1'b1;
        end else if (r_acc_byte == 8'hF0) begin
          r_brk_pf <= 1'b1;
        end else begin
          scan_code  <= r_acc_byte;
          is_ext     <= r_ext_pf;
          is_break   <= r_brk_pf;
          code_valid <= 1'b1;
          r_ext_pf   <= 1'b0;
          r_brk_pf   <= 1'b0;
          // Keypad (non-extended) variants of these codes leave the arrows alone.
          if (r_ext_pf) begin
            case (r_acc_byte)
              8'h75:   kup    <= ~r_brk_pf;
              8'h72:   kdown  <= ~r_brk_pf;
              8'h6B:   kleft  <= ~r_brk_pf;
              8'h74:   kright <= ~r_brk_pf;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus pushes expected events,
// a forked monitor pops and compares whenever code_valid or frame_err fires.
module tb_ps2_key_decoder;
  localparam int TO = 3000;
`ifdef PS2_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b0, keyclk = 1'b1, keyinput = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, is_ext, is_break, kup, kdown, kleft, kright, frame_err;

  always #5 clk = ~clk;

  ps2_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO), .TO_W(12)) dut (
    .clk(clk), .rst(rst), .keyclk(keyclk), .keyinput(keyinput),
    .scan_code(scan_code), .code_valid(code_valid), .is_ext(is_ext), .is_break(is_break),
    .kup(kup), .kdown(kdown), .kleft(kleft), .kright(kright), .frame_err(frame_err));

  typedef struct packed {
    bit       err;
    bit [7:0] code;
    bit       ext;
    bit       brk;
    bit [3:0] arr;   // {up,down,left,right}
  } exp_t;

  exp_t     q[$];
  int       checks = 0, failures = 0;
  bit       m_ext = 0, m_brk = 0;
  bit [3:0] m_held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int aidx(input bit [7:0] b);
    case (b)
      8'h75:   return 3;
      8'h72:   return 2;
      8'h6B:   return 1;
      8'h74:   return 0;
      default: return -1;
    endcase
  endfunction

  // Reference model: what one complete frame should produce.
  task automatic model_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop);
    exp_t e;
    int   k;
    e = '0;
    if (bad_stop || (bad_par && PCHK)) begin
      e.err = 1'b1;
      e.arr = m_held;
      q.push_back(e);
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      k = aidx(b);
      if (m_ext && k >= 0) m_held[k] = !m_brk;
      e.code = b;
      e.ext  = m_ext;
      e.brk  = m_brk;
      e.arr  = m_held;
      q.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input bit v, input int half);
    keyinput = v;
    repeat (half) @(posedge clk);
    #1 keyclk = 1'b0;
    repeat (half) @(posedge clk);
    #1 keyclk = 1'b1;
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                            input int half = 20);
    model_frame(b, bad_par, bad_stop);
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit((~^b) ^ bad_par, half);
    send_bit(!bad_stop, half);
    keyinput = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (code_valid || frame_err)) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {code_valid, frame_err}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("evt_frame_err", frame_err, e.err);
          chk("evt_code_valid", code_valid, !e.err);
          if (!e.err) begin
            chk("scan_code", scan_code, e.code);
            chk("is_ext", is_ext, e.ext);
            chk("is_break", is_break, e.brk);
          end
          chk("arrows", {kup, kdown, kleft, kright}, e.arr);
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_scan_code"}, scan_code, 0);
    chk({name, "_code_valid"}, code_valid, 0);
    chk({name, "_is_ext"}, is_ext, 0);
    chk({name, "_is_break"}, is_break, 0);
    chk({name, "_arrows"}, {kup, kdown, kleft, kright}, 0);
    chk({name, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    bit [7:0] pool [8];
    bit [7:0] b;
    exp_t     te;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h29};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    fork monitor(); join_none
    repeat (5) @(posedge clk);

    // Plain code at wide fall spacing
    send_frame(8'h1C, 0, 0, 1000);
    // Left arrow make / break
    send_frame(8'hE0); send_frame(8'h6B);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
    // Typematic up arrow, then release
    for (int i = 0; i < 3; i++) begin send_frame(8'hE0); send_frame(8'h75); end
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    // Bad parity
    send_frame(8'h1C, 1, 0);
    // Spurious fall with data high while idle: no event
    send_bit(1'b1, 20);
    repeat (10) @(posedge clk);
    // Timeout after 4 data bits clears prefixes
    send_frame(8'hE0);
    te = '0; te.err = 1'b1; te.arr = m_held;
    q.push_back(te);
    m_ext = 1'b0; m_brk = 1'b0;
    send_bit(1'b0, 20);
    for (int i = 0; i < 4; i++) send_bit(i[0], 20);
    keyinput = 1'b1;
    repeat (TO + 50) @(posedge clk);
    send_frame(8'h29);
    // Framing error keeps the E0 prefix
    send_frame(8'hE0); send_frame(8'h74, 0, 1); send_frame(8'h74);
    // Both prefix orderings, and keypad codes ignored for arrows
    send_frame(8'hE0); send_frame(8'h72);
    send_frame(8'hF0); send_frame(8'hE0); send_frame(8'h72);
    send_frame(8'h6B); send_frame(8'hF0); send_frame(8'h74);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      b = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : 8'($urandom);
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, $urandom_range(8, 30));
    end

    // Reset mid-frame with arrows held
    send_frame(8'hE0); send_frame(8'h75);
    send_bit(1'b0, 20);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 20);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    m_ext = 1'b0; m_brk = 1'b0; m_held = '0;
    keyinput = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'hE0); send_frame(8'h6B);

    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("final_arrows", {kup, kdown, kleft, kright}, m_held);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #50ms;
    $display("FAIL time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end
endmodule
